// File: rtl/cpu_pkg.sv
// Shared fetch-side definitions: address width, 2-bit counter encodings, fetch FSM states.
package cpu_pkg;

    localparam int unsigned PC_W = 14;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef enum logic {
        FS_INIT = 1'b0,
        FS_RUN  = 1'b1
    } fetch_state_e;

    // Saturating 2-bit counter step toward the resolved direction.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != CTR_ST) nxt = 2'(ctr + 2'b01);
        end else begin
            if (ctr != CTR_SNT) nxt = 2'(ctr - 2'b01);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// Bimodal 2-bit branch history table with a post-reset initialisation sweep.
module bht_2bit #(
    parameter int unsigned IDX_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_ctr_c,
    input  logic             train_en,
    input  logic [IDX_W-1:0] train_idx,
    input  logic             train_taken,
    output logic             init_done,
    output logic             init_last_c
);
    import cpu_pkg::*;

    localparam int unsigned DEPTH = 2 ** IDX_W;

    fetch_state_e     state_q, state_d;
    logic [IDX_W-1:0] sweep_q, sweep_d;
    logic [1:0]       table_q [DEPTH];

    logic             wr_en_c;
    logic [IDX_W-1:0] wr_idx_c;
    logic [1:0]       wr_val_c;

    // Sweep writes weakly-not-taken everywhere, then the port is handed to training.
    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        wr_en_c     = 1'b0;
        wr_idx_c    = train_idx;
        wr_val_c    = ctr_next(table_q[train_idx], train_taken);
        init_last_c = 1'b0;
        case (state_q)
            FS_INIT: begin
                wr_en_c  = 1'b1;
                wr_idx_c = sweep_q;
                wr_val_c = CTR_WNT;
                sweep_d  = IDX_W'(sweep_q + 1'b1);
                if (sweep_q == {IDX_W{1'b1}}) begin
                    state_d     = FS_RUN;
                    init_last_c = 1'b1;
                end
            end
            FS_RUN: begin
                wr_en_c = train_en;
            end
            default: state_d = FS_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= FS_INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // Storage needs no reset: every entry is rewritten by the sweep.
    always_ff @(posedge clk) begin
        if (wr_en_c) table_q[wr_idx_c] <= wr_val_c;
    end

    assign rd_ctr_c  = table_q[rd_idx];
    assign init_done = (state_q == FS_RUN);

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC register, next-PC selection, redirect flush and mispredict counter.
module fetch_pc_unit #(
    parameter int unsigned PC_W     = cpu_pkg::PC_W,
    parameter int unsigned IDX_W    = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            stall,
    input  logic            pd_is_b,
    input  logic [PC_W-1:0] pd_target,
    input  logic            b_is_hazard,
    input  logic [PC_W-1:0] b_addr,
    input  logic            b_is_b_ope,
    input  logic            b_is_branch,
    input  logic [PC_W-1:0] b_w_pc,
    output logic [PC_W-1:0] pc,
    output logic            pred_taken,
    output logic            f_valid,
    output logic            flush,
    output logic [31:0]     mispred_cnt
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic            f_valid_q, f_valid_d;
    logic            flush_q, flush_d;
    logic [31:0]     cnt_q, cnt_d;

    logic            run_c;
    logic            init_last_c;
    logic [1:0]      rd_ctr_c;
    logic            pred_bit_c;
    logic            train_en_c;
    logic            unused_c;

    bht_2bit #(
        .IDX_W (IDX_W)
    ) u_bht (
        .clk         (clk),
        .rstn        (rstn),
        .rd_idx      (pc_q[IDX_W-1:0]),
        .rd_ctr_c    (rd_ctr_c),
        .train_en    (train_en_c),
        .train_idx   (b_w_pc[IDX_W-1:0]),
        .train_taken (b_is_branch),
        .init_done   (run_c),
        .init_last_c (init_last_c)
    );

    assign pred_bit_c = pd_is_b && rd_ctr_c[1];
    assign train_en_c = run_c && b_is_b_ope;
    assign unused_c   = ^b_w_pc[PC_W-1:IDX_W];

    // Redirect beats stall, stall beats prediction, prediction beats sequential.
    always_comb begin
        pc_d      = pc_q;
        flush_d   = 1'b0;
        cnt_d     = cnt_q;
        f_valid_d = 1'b0;
        if (run_c) begin
            if (b_is_hazard) begin
                pc_d    = b_addr;
                flush_d = 1'b1;
            end else if (stall) begin
                pc_d = pc_q;
            end else if (pred_bit_c) begin
                pc_d = pd_target;
            end else begin
                pc_d = PC_W'(pc_q + 1'b1);
            end
            if (b_is_b_ope && b_is_hazard) cnt_d = 32'(cnt_q + 32'd1);
            f_valid_d = !b_is_hazard;
        end else if (init_last_c) begin
            f_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q      <= PC_W'(RESET_PC);
            f_valid_q <= 1'b0;
            flush_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            pc_q      <= pc_d;
            f_valid_q <= f_valid_d;
            flush_q   <= flush_d;
            cnt_q     <= cnt_d;
        end
    end

    assign pc          = pc_q;
    assign pred_taken  = run_c && pred_bit_c;
    assign f_valid     = f_valid_q;
    assign flush       = flush_q;
    assign mispred_cnt = cnt_q;

endmodule
